// File: rtl/inst_cache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the pipeline plus memory.
interface inst_cache_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_ren;
    logic                  flush;
    logic [31:0]           cpu_inst;
    logic                  cpu_stall;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ren;
    logic [31:0]           mem_data;
    logic                  mem_ack;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport slave (
        input  cpu_addr, cpu_ren, flush, mem_data, mem_ack,
        output cpu_inst, cpu_stall, mem_addr, mem_ren, hit_count, miss_count
    );

    modport master (
        output cpu_addr, cpu_ren, flush, mem_data, mem_ack,
        input  cpu_inst, cpu_stall, mem_addr, mem_ren, hit_count, miss_count
    );
endinterface

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller.
// Hits are served combinationally; a miss holds the pipeline while one memory read fills the line.
module inst_cache_ctrl #(
    parameter int INDEX_WIDTH = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    inst_cache_ctrl_if.slave   bus
);
    localparam int NUM_LINES = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_ren_q, mem_ren_d;
    logic [31:0]           hit_count_q, hit_count_d;
    logic [31:0]           miss_count_q, miss_count_d;

    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES];

    logic [INDEX_WIDTH-1:0] lookup_idx, fill_idx;
    logic [TAG_WIDTH-1:0]   lookup_tag, fill_tag;
    logic                   hit;
    logic                   fill_we;

    assign lookup_idx = bus.cpu_addr[INDEX_WIDTH-1:0];
    assign lookup_tag = bus.cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign fill_idx   = mem_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag   = mem_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];

    // An ack that coincides with a flush belongs to an aborted fill and is dropped.
    assign fill_we = (state_q == FILL) && bus.mem_ack && !bus.flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            mem_addr_q   <= '0;
            mem_ren_q    <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_ren_q    <= mem_ren_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we && !rst) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.mem_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_comb begin
                valid_d[gi] = valid_q[gi];
                if (bus.flush) begin
                    valid_d[gi] = 1'b0;
                end else if (fill_we && (fill_idx == INDEX_WIDTH'(gi))) begin
                    valid_d[gi] = 1'b1;
                end
            end
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_ren_d    = mem_ren_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (bus.flush) begin
            state_d   = IDLE;
            mem_ren_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_ren && !hit) begin
                        mem_addr_d   = bus.cpu_addr;
                        mem_ren_d    = 1'b1;
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = FILL;
                    end else if (hit) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        mem_ren_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        hit = !rst && bus.cpu_ren && (state_q == IDLE) && valid_q[lookup_idx]
              && (tag_mem[lookup_idx] == lookup_tag);
        bus.cpu_inst   = hit ? data_mem[lookup_idx] : 32'd0;
        bus.cpu_stall  = !rst && bus.cpu_ren && !hit;
        bus.mem_addr   = mem_addr_q;
        bus.mem_ren    = mem_ren_q;
        bus.hit_count  = hit_count_q;
        bus.miss_count = miss_count_q;
    end
endmodule
